risac_ifetch_buf: RTL and testbench
===================================

// Module: risac_ifetch_buf
// PURPOSE
//  Sequential instruction prefetch buffer between the risac core's Ibus port and a pipelined memory with readdatavalid.
//  Streams word reads ahead of the core's PC and returns {instr, instrAddr} from a small queue.
//  On a PC mismatch (branch/jump) it flushes the queue, discards in-flight responses and refetches from the new PC.
// PARAMETERS
//  DEPTH    4  queue entries (power of 2, >=2); also max live in-flight + queued words
//  MAX_OUT  4  max total outstanding memory reads (live + to-be-dropped)
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   reset, asynchronous, active-low
//  iCoreAddr     in   32  core PC (byte address, word aligned)
//  iCoreRead     in   1   core requests instruction at iCoreAddr
//  oCoreData     out  32  instruction; valid when iCoreRead && !oCoreWait
//  oCoreIAddr    out  32  address of oCoreData
//  oCoreWait     out  1   1 = no instruction for iCoreAddr this cycle
//  oMemAddr      out  32  memory read address (word aligned)
//  oMemRead      out  1   memory read request
//  iMemWait      in   1   waitrequest; request accepted when oMemRead && !iMemWait
//  iMemData      in   32  read data
//  iMemDataValid in   1   read data valid; responses in request order
// BEHAVIOUR
//  Reset: queue empty, oMemRead=0, oMemAddr=0, fetchAddr=0, expAddr=0, liveCnt=dropCnt=0, state=STREAM;
//   oCoreWait=1, oCoreData=0, oCoreIAddr=0 (outputs driven from queue head, zero when empty).
//  Core side (combinational): hit = iCoreRead && !empty && headAddr==iCoreAddr; oCoreWait=!hit; pop on hit.
//   Queue hit returns data in the same cycle as the request (0-cycle latency); core holds PC while oCoreWait=1.
//  Mismatch: iCoreRead && iCoreAddr!=expAddr -> flush: queue cleared, dropCnt += liveCnt (after this cycle's
//   accounting), liveCnt=0, expAddr=iCoreAddr. expAddr = address of next word to be enqueued; +4 per push.
//  Memory side: issue when state==STREAM && (count+liveCnt) < DEPTH && (liveCnt+dropCnt) < MAX_OUT.
//   oMemAddr=fetchAddr; fetchAddr += 4 on acceptance; liveCnt++ on acceptance.
//   oMemRead/oMemAddr must stay stable while iMemWait=1 (no withdrawal, no address change).
//  FSM: STREAM -> HOLD when flush occurs while oMemRead && iMemWait (stalled request cannot be retargeted);
//   HOLD: keep request; on acceptance it counts to dropCnt, fetchAddr<=redirAddr, -> STREAM.
//   Flush with no stalled request: fetchAddr<=iCoreAddr next cycle, stay STREAM. Second flush in HOLD updates redirAddr.
//  Response: iMemDataValid with dropCnt>0 -> discard, dropCnt--; else push {iMemData, expAddr}, liveCnt--.
//  Simultaneous: response + flush same cycle -> response is discarded (not pushed), counted as its own decrement;
//   acceptance + flush same cycle -> that request is dropped; pop + push same cycle -> count unchanged.
//  Queue never overflows by construction; push when full is an assertion failure.
//  iCoreRead=0: no pop, no flush; prefetch continues until queue+live reach DEPTH.
//  Reset mid-operation: all state cleared immediately; stale responses after reset are a system error (memory reset too).
//  Counters: liveCnt, dropCnt width clog2(MAX_OUT+1); never underflow (assert).
// STRUCTURE
//  Shared header risac_defs.vh: XLEN=32, word-step constant 4, FSM state encodings STREAM/HOLD.
//  One sub-module: risac_fifo (sync FIFO, WIDTH=64, DEPTH param, push/pop/flush, full/empty/count).
//  Top holds FSM, fetchAddr/expAddr/redirAddr regs, liveCnt/dropCnt counters, hit/flush logic.
// TESTING
//  1 Reset, core reads PC=0, memory 1-cycle latency no wait -> words 0,4,8,C returned in order, oCoreWait=0 every cycle after fill.
//  2 Core stalls (iCoreRead=0) 10 cycles -> exactly DEPTH=4 reads issued, oMemRead=0 afterwards, no overflow.
//  3 After fetching 0x0/0x4, core requests 0x100 with 2 reads in flight -> both discarded, next delivered oCoreIAddr=0x100.
//  4 Flush while iMemWait=1 on addr 0x8 -> oMemAddr stays 0x8 until accepted, then 0x200 issued; core sees 0x200 first.
//  5 iMemDataValid coincident with flush to 0x40 -> that word dropped, dropCnt returns to 0, 0x40 delivered.
//  6 Assert rst_n low mid-stream -> oMemRead=0, oCoreWait=1 same cycle; after release fetch restarts at 0x0.

Source files
------------

// File: rtl/risac_ifetch_buf_pkg.sv
// Shared types and constants for the risac instruction prefetch buffer.
package risac_ifetch_buf_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] WORD_STEP = 32'd4;

    typedef enum logic {
        STREAM = 1'b0,
        HOLD   = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
    } ibuf_entry_t;
endpackage

// File: rtl/risac_fifo.sv
// Small synchronous FIFO with single-cycle flush; read data is the current head.
module risac_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage is not reset; the head is only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/risac_ifetch_buf.sv
// Sequential instruction prefetcher: streams word reads ahead of the core PC and
// serves {instr, addr} from a small queue, refetching on any PC discontinuity.
module risac_ifetch_buf
    import risac_ifetch_buf_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] iCoreAddr,
    input  logic            iCoreRead,
    output logic [XLEN-1:0] oCoreData,
    output logic [XLEN-1:0] oCoreIAddr,
    output logic            oCoreWait,
    output logic [XLEN-1:0] oMemAddr,
    output logic            oMemRead,
    input  logic            iMemWait,
    input  logic [XLEN-1:0] iMemData,
    input  logic            iMemDataValid
);
    localparam int CW = $clog2(MAX_OUT+1);
    localparam int QW = $clog2(DEPTH+1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_q, fetch_d, exp_q, exp_d, redir_q, redir_d;
    logic [CW-1:0]   live_q, live_d, drop_q, drop_d, live_a, drop_a;
    logic            mem_rd_q, mem_rd_d;
    logic            empty, full, hit, flush, push, acc, resp_live, resp_drop;
    logic [QW-1:0]   count, count_d;
    ibuf_entry_t     head, wentry;

    risac_fifo #(.WIDTH($bits(ibuf_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (hit),
        .flush_i (flush),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        hit       = iCoreRead && !empty && (head.addr == iCoreAddr);
        // A non-matching head, or an empty queue not waiting on iCoreAddr, is a redirect.
        flush     = iCoreRead && !hit && (!empty || (iCoreAddr != exp_q));
        acc       = mem_rd_q && !iMemWait;
        resp_drop = iMemDataValid && (drop_q != '0);
        resp_live = iMemDataValid && (drop_q == '0);
        push      = resp_live && !flush;
        wentry    = '{instr: iMemData, addr: exp_q};

        live_a  = live_q + CW'(acc && state_q == STREAM) - CW'(resp_live);
        drop_a  = drop_q + CW'(acc && state_q == HOLD) - CW'(resp_drop);
        live_d  = flush ? '0 : live_a;
        drop_d  = flush ? drop_a + live_a : drop_a;
        count_d = flush ? '0 : count + QW'(push) - QW'(hit);
        exp_d   = flush ? iCoreAddr : (push ? exp_q + WORD_STEP : exp_q);

        state_d = state_q;
        fetch_d = fetch_q;
        redir_d = redir_q;
        case (state_q)
            STREAM: begin
                if (flush && mem_rd_q && iMemWait) begin
                    state_d = HOLD;
                    redir_d = iCoreAddr;
                end else if (flush) begin
                    fetch_d = iCoreAddr;
                end else if (acc) begin
                    fetch_d = fetch_q + WORD_STEP;
                end
            end
            HOLD: begin
                if (flush) redir_d = iCoreAddr;
                if (acc) begin
                    state_d = STREAM;
                    fetch_d = redir_d;
                end
            end
            default: state_d = STREAM;
        endcase

        // A stalled request is never withdrawn or retargeted.
        if (mem_rd_q && iMemWait)
            mem_rd_d = 1'b1;
        else
            mem_rd_d = (state_d == STREAM) &&
                       (int'(count_d) + int'(live_d) < DEPTH) &&
                       (int'(live_d) + int'(drop_d) < MAX_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STREAM;
            fetch_q  <= '0;
            exp_q    <= '0;
            redir_q  <= '0;
            live_q   <= '0;
            drop_q   <= '0;
            mem_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fetch_q  <= fetch_d;
            exp_q    <= exp_d;
            redir_q  <= redir_d;
            live_q   <= live_d;
            drop_q   <= drop_d;
            mem_rd_q <= mem_rd_d;
        end
    end

    assign oCoreWait  = !hit;
    assign oCoreData  = empty ? '0 : head.instr;
    assign oCoreIAddr = empty ? '0 : head.addr;
    assign oMemRead   = mem_rd_q;
    assign oMemAddr   = fetch_q;

    a_no_overflow:   assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_live_nounder:  assert property (@(posedge clk) disable iff (!rst_n) !(resp_live && live_q == '0));
endmodule

// File: tb/tb_risac_ifetch_buf.sv
// Scoreboard bench for risac_ifetch_buf: expected core fetches are queued as the
// core PC stream is driven and retired as the DUT delivers them.
module tb_risac_ifetch_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iCoreAddr, oCoreData, oCoreIAddr, oMemAddr, iMemData;
    logic        iCoreRead, oCoreWait, oMemRead, iMemWait, iMemDataValid;

    risac_ifetch_buf dut (
        .clk(clk), .rst_n(rst_n),
        .iCoreAddr(iCoreAddr), .iCoreRead(iCoreRead),
        .oCoreData(oCoreData), .oCoreIAddr(oCoreIAddr), .oCoreWait(oCoreWait),
        .oMemAddr(oMemAddr), .oMemRead(oMemRead), .iMemWait(iMemWait),
        .iMemData(iMemData), .iMemDataValid(iMemDataValid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } rsp_t;

    logic [31:0] sb[$];       // expected core PC stream
    rsp_t        rsp_q[$];    // memory model pipeline
    logic [31:0] acc_log[$];  // accepted memory addresses
    int n_chk = 0, n_fail = 0;
    int cyc_n = 0, lat = 1, n_dlv = 0, first_dlv = 0, last_dlv = 0, t0 = 0;
    int wait_left = 0;
    logic [31:0] wait_at = '0, prev_addr = '0;
    logic prev_stall = 1'b0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0] ^ 16'h1234};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle; entered and left at a falling edge.
    task automatic tick();
        iCoreRead     = (sb.size() != 0);
        iCoreAddr     = (sb.size() != 0) ? sb[0] : 32'h0;
        iMemDataValid = 1'b0;
        iMemData      = '0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc_n) begin
            iMemDataValid = 1'b1;
            iMemData      = mdata(rsp_q[0].addr);
            void'(rsp_q.pop_front());
        end
        iMemWait = oMemRead && (oMemAddr == wait_at) && (wait_left > 0);
        if (iMemWait) wait_left--;
        #1;
        if (prev_stall) begin
            chk("mem_hold_rd", 64'(oMemRead), 64'd1);
            chk("mem_hold_addr", 64'(oMemAddr), 64'(prev_addr));
        end
        if (iCoreRead && !oCoreWait) begin
            chk("core_iaddr", 64'(oCoreIAddr), 64'(sb[0]));
            chk("core_data", 64'(oCoreData), 64'(mdata(sb[0])));
            if (n_dlv == 0) first_dlv = cyc_n;
            last_dlv = cyc_n;
            n_dlv++;
            void'(sb.pop_front());
        end
        if (oMemRead && !iMemWait) begin
            rsp_q.push_back('{addr: oMemAddr, due: cyc_n + lat});
            acc_log.push_back(oMemAddr);
        end
        prev_stall = oMemRead && iMemWait;
        prev_addr  = oMemAddr;
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic run(input logic [31:0] start, input int n, input int budget);
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
        n_dlv = 0;
        t0 = cyc_n;
        for (int c = 0; c < budget && sb.size() != 0; c++) tick();
        chk("deliver_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete(); rsp_q.delete(); acc_log.delete();
        prev_stall = 1'b0; wait_left = 0; lat = 1;
        iCoreRead = 1'b0; iCoreAddr = '0; iMemWait = 1'b0;
        iMemData = '0; iMemDataValid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iCoreRead = 1'b1; iCoreAddr = '0; iMemWait = 1'b0;
        iMemData = '0; iMemDataValid = 1'b0;
        #1;
        chk("rst_memread", 64'(oMemRead), 64'd0);
        chk("rst_memaddr", 64'(oMemAddr), 64'd0);
        chk("rst_corewait", 64'(oCoreWait), 64'd1);
        chk("rst_coredata", 64'(oCoreData), 64'd0);
        chk("rst_coreiaddr", 64'(oCoreIAddr), 64'd0);
        @(negedge clk);

        // 1: stream from 0, one word per cycle once filled
        do_reset();
        run(32'h0, 4, 40);
        chk("t1_count", 64'(n_dlv), 64'd4);
        chk("t1_back2back", 64'(last_dlv - first_dlv), 64'd3);

        // 2: idle core -> prefetch stops at DEPTH, then 0-latency queue hits
        do_reset();
        repeat (10) tick();
        chk("t2_issued", 64'(acc_log.size()), 64'd4);
        chk("t2_rd_idle", 64'(oMemRead), 64'd0);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            chk("t2_addr", 64'(acc_log[i]), 64'(4 * i));
        run(32'h0, 4, 40);
        chk("t2_zero_lat", 64'(first_dlv - t0), 64'd0);
        chk("t2_back2back", 64'(last_dlv - first_dlv), 64'd3);

        // 3: jump to 0x100 with reads in flight
        do_reset();
        lat = 3;
        run(32'h0, 2, 40);
        run(32'h100, 3, 60);
        chk("t3_drop_clear", 64'(dut.drop_q), 64'd0);

        // 4: redirect while the 0x8 read is stalled
        do_reset();
        wait_at = 32'h8; wait_left = 6;
        run(32'h0, 2, 40);
        run(32'h200, 2, 60);
        chk("t4_log_len", 64'(acc_log.size() >= 4), 64'd1);
        if (acc_log.size() >= 4) begin
            chk("t4_stalled", 64'(acc_log[2]), 64'h8);
            chk("t4_redir", 64'(acc_log[3]), 64'h200);
        end

        // 5: redirect to 0x40 in the same cycle a response returns
        do_reset();
        run(32'h0, 2, 40);
        run(32'h40, 3, 60);
        repeat (4) tick();
        chk("t5_drop_zero", 64'(dut.drop_q), 64'd0);

        // 6: reset in mid-stream
        do_reset();
        for (int i = 0; i < 16; i++) sb.push_back(32'(4 * i));
        repeat (6) tick();
        chk("t6_pre_rd", 64'(oMemRead), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rd", 64'(oMemRead), 64'd0);
        chk("t6_rst_wait", 64'(oCoreWait), 64'd1);
        do_reset();
        run(32'h0, 4, 40);
        chk("t6_restart", 64'(acc_log.size() > 0 ? acc_log[0] : 32'hFFFF_FFFF), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
